load_store_requester: RTL and testbench

Initiator side of the data-memory request/response protocol. Sits between the load/store reservation station and `data_mem`. It accepts one load or store per handshake, formats it into a left-justified big-endian byte-lane request, and tracks outstanding requests in order. It then formats each load response (zero or sign extension) into a 32-bit GPR result. Misaligned splitting is done downstream in `data_mem`; this block never splits.

---
 rtl/ppc_types.sv | 63 ++++++
 rtl/pending_fifo.sv | 54 +++++
 rtl/load_store_requester.sv | 151 +++++++++++++++
 tb/tb_load_store_requester.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppc_types.sv
// Shared types for the data-memory request path.
// Size encoding, pending-entry bundle and lane helpers.
package ppc_types;

    typedef enum logic [0:1] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } mem_size_t;

    localparam int RS_ID_MAX = 8;

    typedef struct packed {
        logic [RS_ID_MAX-1:0] rs_id;
        logic [1:0]           size;
        logic                 sign_ext;
        logic                 is_store;
    } pending_entry_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        m = 4'b1111;
        unique case (1'b1)
            (size == SIZE_BYTE): m = 4'b1000;
            (size == SIZE_HALF): m = 4'b1100;
            default:             m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_align(
        input logic [1:0]  size,
        input logic [31:0] d
    );
        logic [31:0] r;
        r = d;
        unique case (1'b1)
            (size == SIZE_BYTE): r = {d[7:0], 24'b0};
            (size == SIZE_HALF): r = {d[15:0], 16'b0};
            default:             r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extract(
        input logic [1:0]  size,
        input logic        sext,
        input logic [31:0] rd
    );
        logic [31:0] r;
        r = rd;
        unique case (1'b1)
            (size == SIZE_BYTE):
                r = {{24{sext & rd[31]}}, rd[31:24]};
            (size == SIZE_HALF):
                r = {{16{sext & rd[31]}}, rd[31:16]};
            default:
                r = rd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pending_fifo.sv
// In-order tracker of outstanding memory requests.
// Power-of-two depth so pointers wrap naturally.
module pending_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/load_store_requester.sv
// Load/store initiator: formats requests to data_mem and
// turns in-order responses into GPR results.
module load_store_requester
    import ppc_types::*;
#(
    parameter int RS_ID_WIDTH   = 5,
    parameter int PENDING_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [RS_ID_WIDTH-1:0] op_rs_id,
    input  logic [4:0]             op_reg_addr,
    input  logic [31:0]            op_address,
    input  logic [1:0]             op_size,
    input  logic                   op_is_store,
    input  logic                   op_sign_ext,
    input  logic [31:0]            op_store_data,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [RS_ID_WIDTH-1:0] mem_rs_id,
    output logic [4:0]             mem_reg_addr,
    output logic [31:0]            mem_address,
    output logic [3:0]             mem_write_en,
    output logic [31:0]            mem_write_data,
    output logic [3:0]             mem_read_en,
    input  logic                   rsp_valid,
    output logic                   rsp_ready,
    input  logic [RS_ID_WIDTH-1:0] rsp_rs_id,
    input  logic [4:0]             rsp_reg_addr,
    input  logic [31:0]            rsp_read_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [RS_ID_WIDTH-1:0] res_rs_id,
    output logic [4:0]             res_reg_addr,
    output logic [31:0]            res_data,
    output logic                   protocol_err
);
    localparam int CW = $clog2(PENDING_DEPTH) + 1;

    logic           en_q;
    logic           fifo_empty;
    logic           fifo_full;
    logic [CW-1:0]  fifo_count;
    logic           can_push;
    pending_entry_t push_entry;
    pending_entry_t head;
    logic           op_fire;
    logic           rsp_fire;
    logic           pop;
    logic           load_rsp;
    logic           id_bad;
    logic [3:0]     mask;

    assign can_push = !fifo_full
                   && (fifo_count < CW'(PENDING_DEPTH));
    assign op_ready = en_q && (!mem_valid || mem_ready)
                   && can_push;
    // Stray responses are drained even when a result is stalled.
    assign rsp_ready = en_q
                    && (!res_valid || res_ready || fifo_empty);

    assign op_fire  = op_valid && op_ready;
    assign rsp_fire = rsp_valid && rsp_ready;
    assign pop      = rsp_fire && !fifo_empty;
    assign load_rsp = pop && !head.is_store;
    assign id_bad   = head.rs_id != RS_ID_MAX'(rsp_rs_id);
    assign mask     = size_mask(op_size);

    always_comb begin
        push_entry          = '0;
        push_entry.rs_id    = RS_ID_MAX'(op_rs_id);
        push_entry.size     = op_size;
        push_entry.sign_ext = op_sign_ext;
        push_entry.is_store = op_is_store;
    end

    pending_fifo #(
        .WIDTH ($bits(pending_entry_t)),
        .DEPTH (PENDING_DEPTH)
    ) u_pending (
        .clk   (clk),
        .rst   (rst),
        .push  (op_fire),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q           <= 1'b0;
            mem_valid      <= 1'b0;
            mem_rs_id      <= '0;
            mem_reg_addr   <= '0;
            mem_address    <= '0;
            mem_write_en   <= '0;
            mem_write_data <= '0;
            mem_read_en    <= '0;
        end else begin
            en_q <= 1'b1;
            if (op_fire) begin
                mem_valid    <= 1'b1;
                mem_rs_id    <= op_rs_id;
                mem_reg_addr <= op_reg_addr;
                mem_address  <= op_address;
                if (op_is_store) begin
                    mem_write_en   <= mask;
                    mem_read_en    <= 4'b0000;
                    mem_write_data <= store_align(op_size,
                                                  op_store_data);
                end else begin
                    mem_write_en   <= 4'b0000;
                    mem_read_en    <= mask;
                    mem_write_data <= '0;
                end
            end else if (mem_ready) begin
                mem_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid    <= 1'b0;
            res_rs_id    <= '0;
            res_reg_addr <= '0;
            res_data     <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (load_rsp) begin
                res_valid    <= 1'b1;
                res_rs_id    <= head.rs_id[RS_ID_WIDTH-1:0];
                res_reg_addr <= rsp_reg_addr;
                res_data     <= load_extract(head.size,
                                             head.sign_ext,
                                             rsp_read_data);
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
            if (rsp_fire && (fifo_empty || id_bad)) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_store_requester.sv
// Bench for load_store_requester: vector table plus
// scoreboarded corner sequences.
module tb_load_store_requester;
    import ppc_types::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 0, op_ready;
    logic [4:0]  op_rs_id = 0, op_reg_addr = 0;
    logic [31:0] op_address = 0, op_store_data = 0;
    logic [1:0]  op_size = 0;
    logic        op_is_store = 0, op_sign_ext = 0;
    logic        mem_valid, mem_ready = 1;
    logic [4:0]  mem_rs_id, mem_reg_addr;
    logic [31:0] mem_address, mem_write_data;
    logic [3:0]  mem_write_en, mem_read_en;
    logic        rsp_valid = 0, rsp_ready;
    logic [4:0]  rsp_rs_id = 0, rsp_reg_addr = 0;
    logic [31:0] rsp_read_data = 0;
    logic        res_valid, res_ready = 1;
    logic [4:0]  res_rs_id, res_reg_addr;
    logic [31:0] res_data;
    logic        protocol_err;

    always #5 clk = ~clk;

    load_store_requester #(.RS_ID_WIDTH(5), .PENDING_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_rs_id(op_rs_id), .op_reg_addr(op_reg_addr),
        .op_address(op_address), .op_size(op_size),
        .op_is_store(op_is_store), .op_sign_ext(op_sign_ext),
        .op_store_data(op_store_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rs_id(mem_rs_id), .mem_reg_addr(mem_reg_addr),
        .mem_address(mem_address), .mem_write_en(mem_write_en),
        .mem_write_data(mem_write_data), .mem_read_en(mem_read_en),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rs_id(rsp_rs_id), .rsp_reg_addr(rsp_reg_addr),
        .rsp_read_data(rsp_read_data),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_rs_id(res_rs_id), .res_reg_addr(res_reg_addr),
        .res_data(res_data), .protocol_err(protocol_err)
    );

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        logic [3:0]  we;
        logic [3:0]  re;
        logic [31:0] wd;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rg;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [3:0]  re;
        logic [31:0] wd;
    } req_t;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rg;
        logic [31:0] data;
    } res_t;

    req_t exp_req[$];
    res_t exp_res[$];
    vec_t vecs[10];
    int   n_tests = 0;
    int   n_fail = 0;
    logic op_acc = 0, rsp_acc = 0;

    function automatic logic [4:0] ra(input logic [4:0] r);
        return ~r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        req_t r;
        res_t s;
        op_acc  = op_valid && op_ready;
        rsp_acc = rsp_valid && rsp_ready;
        if (mem_valid && mem_ready) begin
            if (exp_req.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL req_unexpected: addr %h", mem_address);
            end else begin
                r = exp_req.pop_front();
                check("req_addr", mem_address, r.addr);
                check("req_we", 32'(mem_write_en), 32'(r.we));
                check("req_re", 32'(mem_read_en), 32'(r.re));
                check("req_wd", mem_write_data, r.wd);
                check("req_rs", 32'(mem_rs_id), 32'(r.rs));
                check("req_reg", 32'(mem_reg_addr), 32'(r.rg));
            end
        end
        if (res_valid && res_ready) begin
            if (exp_res.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL res_unexpected: data %h", res_data);
            end else begin
                s = exp_res.pop_front();
                check("res_data", res_data, s.data);
                check("res_rs", 32'(res_rs_id), 32'(s.rs));
                check("res_reg", 32'(res_reg_addr), 32'(s.rg));
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_op(input logic st, input logic [1:0] sz,
                            input logic sx, input logic [31:0] a,
                            input logic [31:0] d, input logic [4:0] rs,
                            input logic [3:0] we, input logic [3:0] re,
                            input logic [31:0] wd);
        logic ok;
        op_is_store = st;
        op_size = sz;
        op_sign_ext = sx;
        op_address = a;
        op_store_data = d;
        op_rs_id = rs;
        op_reg_addr = ra(rs);
        op_valid = 1'b1;
        exp_req.push_back('{rs, ra(rs), a, we, re, wd});
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (op_acc) begin
                ok = 1'b1;
                break;
            end
        end
        op_valid = 1'b0;
        check("op_accept", 32'(ok), 32'd1);
        if (ok) check("req_latency", 32'(mem_valid), 32'd1);
    endtask

    task automatic send_rsp(input logic [4:0] rs, input logic [31:0] rd,
                            input logic has_res, input logic [4:0] ers,
                            input logic [31:0] edata);
        logic ok;
        rsp_rs_id = rs;
        rsp_reg_addr = ra(rs);
        rsp_read_data = rd;
        rsp_valid = 1'b1;
        if (has_res) exp_res.push_back('{ers, ra(rs), edata});
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rsp_acc) begin
                ok = 1'b1;
                break;
            end
        end
        rsp_valid = 1'b0;
        check("rsp_accept", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ok;
        vecs[0] = '{1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0,
                    4'hF, 4'h0, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{0, 2'b01, 1, 32'h200, 32'hFFFFFFFF, 32'h80011234,
                    4'h0, 4'hC, 32'h0, 32'hFFFF8001};
        vecs[2] = '{0, 2'b01, 0, 32'h202, 32'hFFFFFFFF, 32'h80011234,
                    4'h0, 4'hC, 32'h0, 32'h00008001};
        vecs[3] = '{1, 2'b00, 0, 32'h103, 32'h123456AB, 32'h0,
                    4'h8, 4'h0, 32'hAB000000, 32'h0};
        vecs[4] = '{0, 2'b00, 1, 32'h301, 32'hFFFFFFFF, 32'hF0123456,
                    4'h0, 4'h8, 32'h0, 32'hFFFFFFF0};
        vecs[5] = '{0, 2'b00, 0, 32'h302, 32'hFFFFFFFF, 32'hF0123456,
                    4'h0, 4'h8, 32'h0, 32'h000000F0};
        vecs[6] = '{0, 2'b10, 1, 32'h400, 32'hFFFFFFFF, 32'hCAFEF00D,
                    4'h0, 4'hF, 32'h0, 32'hCAFEF00D};
        vecs[7] = '{1, 2'b11, 0, 32'h404, 32'h11223344, 32'h0,
                    4'hF, 4'h0, 32'h11223344, 32'h0};
        vecs[8] = '{1, 2'b01, 0, 32'h406, 32'h0000BEEF, 32'h0,
                    4'hC, 4'h0, 32'hBEEF0000, 32'h0};
        vecs[9] = '{0, 2'b01, 1, 32'h408, 32'hFFFFFFFF, 32'h7FFF0000,
                    4'h0, 4'hC, 32'h0, 32'h00007FFF};

        #1;
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_op_ready", 32'(op_ready), 32'd0);
        check("rst_rsp_ready", 32'(rsp_ready), 32'd0);
        check("rst_err", 32'(protocol_err), 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        #21;
        rst = 1'b1;
        step();
        step();
        check("op_ready_up", 32'(op_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            issue_op(vecs[i].st, vecs[i].sz, vecs[i].sx, vecs[i].addr,
                     vecs[i].data, 5'(i + 1), vecs[i].we, vecs[i].re,
                     vecs[i].wd);
            send_rsp(5'(i + 1), vecs[i].rdata, !vecs[i].st, 5'(i + 1),
                     vecs[i].res);
            check("res_valid_after_rsp", 32'(res_valid),
                  32'(!vecs[i].st));
            step();
            step();
        end
        check("tbl_req_drain", 32'(exp_req.size()), 32'd0);
        check("tbl_res_drain", 32'(exp_res.size()), 32'd0);
        check("tbl_no_err", 32'(protocol_err), 32'd0);

        mem_ready = 1'b0;
        issue_op(0, 2'b10, 0, 32'h500, 32'h0, 5'd10, 4'h0, 4'hF, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_op_ready", 32'(op_ready), 32'd0);
            check("stall_hold_addr", mem_address, 32'h500);
            check("stall_hold_valid", 32'(mem_valid), 32'd1);
        end
        mem_ready = 1'b1;
        issue_op(0, 2'b10, 0, 32'h504, 32'h0, 5'd11, 4'h0, 4'hF, 32'h0);
        issue_op(0, 2'b10, 0, 32'h508, 32'h0, 5'd12, 4'h0, 4'hF, 32'h0);
        issue_op(0, 2'b10, 0, 32'h50C, 32'h0, 5'd13, 4'h0, 4'hF, 32'h0);
        check("full_op_ready", 32'(op_ready), 32'd0);
        op_rs_id = 5'd14;
        op_reg_addr = ra(5'd14);
        op_address = 32'h510;
        op_is_store = 1'b0;
        op_size = 2'b10;
        op_valid = 1'b1;
        exp_req.push_back('{5'd14, ra(5'd14), 32'h510, 4'h0, 4'hF, 32'h0});
        step();
        check("full_block", 32'(op_ready), 32'd0);
        step();
        check("full_block", 32'(op_ready), 32'd0);
        send_rsp(5'd10, 32'hA0A0A0A0, 1, 5'd10, 32'hA0A0A0A0);
        check("full_recover", 32'(op_ready), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (op_acc) begin
                ok = 1'b1;
                break;
            end
        end
        op_valid = 1'b0;
        check("late_accept", 32'(ok), 32'd1);
        send_rsp(5'd11, 32'hB1B1B1B1, 1, 5'd11, 32'hB1B1B1B1);
        send_rsp(5'd12, 32'hC2C2C2C2, 1, 5'd12, 32'hC2C2C2C2);
        send_rsp(5'd13, 32'hD3D3D3D3, 1, 5'd13, 32'hD3D3D3D3);
        send_rsp(5'd14, 32'hE4E4E4E4, 1, 5'd14, 32'hE4E4E4E4);
        step();
        step();
        check("burst_req_drain", 32'(exp_req.size()), 32'd0);
        check("burst_res_drain", 32'(exp_res.size()), 32'd0);

        issue_op(0, 2'b10, 0, 32'h600, 32'h0, 5'd20, 4'h0, 4'hF, 32'h0);
        issue_op(0, 2'b10, 0, 32'h604, 32'h0, 5'd21, 4'h0, 4'hF, 32'h0);
        res_ready = 1'b0;
        send_rsp(5'd20, 32'h11111111, 1, 5'd20, 32'h11111111);
        check("bp_res_valid", 32'(res_valid), 32'd1);
        rsp_rs_id = 5'd21;
        rsp_reg_addr = ra(5'd21);
        rsp_read_data = 32'h22222222;
        rsp_valid = 1'b1;
        exp_res.push_back('{5'd21, ra(5'd21), 32'h22222222});
        for (int k = 0; k < 2; k++) begin
            step();
            check("bp_rsp_block", 32'(rsp_ready), 32'd0);
            check("bp_res_hold_rs", 32'(res_rs_id), 32'd20);
            check("bp_res_hold_data", res_data, 32'h11111111);
        end
        res_ready = 1'b1;
        step();
        rsp_valid = 1'b0;
        check("bp_rsp_accept", 32'(rsp_acc), 32'd1);
        step();
        step();
        check("bp_res_drain", 32'(exp_res.size()), 32'd0);

        check("err_clear", 32'(protocol_err), 32'd0);
        send_rsp(5'd7, 32'h0, 0, 5'd0, 32'h0);
        step();
        check("err_stray", 32'(protocol_err), 32'd1);
        check("stray_no_res", 32'(res_valid), 32'd0);
        issue_op(0, 2'b10, 0, 32'h700, 32'h0, 5'd3, 4'h0, 4'hF, 32'h0);
        send_rsp(5'd9, 32'h33333333, 1, 5'd3, 32'h33333333);
        step();
        step();
        check("err_sticky", 32'(protocol_err), 32'd1);
        check("mismatch_drain", 32'(exp_res.size()), 32'd0);

        issue_op(0, 2'b10, 0, 32'h800, 32'h0, 5'd5, 4'h0, 4'hF, 32'h0);
        res_ready = 1'b0;
        send_rsp(5'd5, 32'h44444444, 1, 5'd5, 32'h44444444);
        mem_ready = 1'b0;
        issue_op(0, 2'b10, 0, 32'h804, 32'h0, 5'd6, 4'h0, 4'hF, 32'h0);
        check("pre_rst_mem_valid", 32'(mem_valid), 32'd1);
        check("pre_rst_res_valid", 32'(res_valid), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_mem_valid", 32'(mem_valid), 32'd0);
        check("arst_res_valid", 32'(res_valid), 32'd0);
        check("arst_op_ready", 32'(op_ready), 32'd0);
        check("arst_rsp_ready", 32'(rsp_ready), 32'd0);
        check("arst_err", 32'(protocol_err), 32'd0);
        check("arst_addr", mem_address, 32'd0);
        check("arst_res_data", res_data, 32'd0);
        check("arst_read_en", 32'(mem_read_en), 32'd0);
        exp_req.delete();
        exp_res.delete();
        mem_ready = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        step();
        step();
        check("post_rst_op_ready", 32'(op_ready), 32'd1);
        issue_op(0, 2'b00, 0, 32'h900, 32'h0, 5'd1, 4'h0, 4'h8, 32'h0);
        send_rsp(5'd1, 32'h5A000000, 1, 5'd1, 32'h0000005A);
        step();
        step();
        check("post_rst_no_err", 32'(protocol_err), 32'd0);
        check("post_rst_drain", 32'(exp_res.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
